sa_write_arbiter: RTL and testbench

//  Per-slave write arbiter: shares one slave's AW and W channels among MST_AMT dispatchers.

---
 rtl/sa_write_arbiter.sv | 169 ++++++++++++++++
 tb/tb_sa_write_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/sa_write_arbiter.sv
// Per-slave write arbiter: round-robin AW grant into a registered slice, with an order FIFO
// that steers W beats from masters in the same order their AWs were granted.
module sa_write_arbiter #(
    parameter int MST_AMT           = 2,
    parameter int OUTSTANDING_AMT   = 8,
    parameter int DATA_WIDTH        = 32,
    parameter int ADDR_WIDTH        = 32,
    parameter int TRANS_MST_ID_W    = 5,
    parameter int TRANS_BURST_W     = 2,
    parameter int TRANS_DATA_LEN_W  = 3,
    parameter int TRANS_DATA_SIZE_W = 3,
    parameter int MST_ID_W          = $clog2(MST_AMT)
) (
    input  logic                                  ACLK_i,
    input  logic                                  ARESETn_i,
    input  logic [TRANS_MST_ID_W*MST_AMT-1:0]     dsp_AWID_i,
    input  logic [ADDR_WIDTH*MST_AMT-1:0]         dsp_AWADDR_i,
    input  logic [TRANS_BURST_W*MST_AMT-1:0]      dsp_AWBURST_i,
    input  logic [TRANS_DATA_LEN_W*MST_AMT-1:0]   dsp_AWLEN_i,
    input  logic [TRANS_DATA_SIZE_W*MST_AMT-1:0]  dsp_AWSIZE_i,
    input  logic [MST_AMT-1:0]                    dsp_AWVALID_i,
    output logic [MST_AMT-1:0]                    dsp_AWREADY_o,
    input  logic [DATA_WIDTH*MST_AMT-1:0]         dsp_WDATA_i,
    input  logic [MST_AMT-1:0]                    dsp_WLAST_i,
    input  logic [MST_AMT-1:0]                    dsp_WVALID_i,
    output logic [MST_AMT-1:0]                    dsp_WREADY_o,
    output logic [TRANS_MST_ID_W+MST_ID_W-1:0]    s_AWID_o,
    output logic [ADDR_WIDTH-1:0]                 s_AWADDR_o,
    output logic [TRANS_BURST_W-1:0]              s_AWBURST_o,
    output logic [TRANS_DATA_LEN_W-1:0]           s_AWLEN_o,
    output logic [TRANS_DATA_SIZE_W-1:0]          s_AWSIZE_o,
    output logic                                  s_AWVALID_o,
    input  logic                                  s_AWREADY_i,
    output logic [DATA_WIDTH-1:0]                 s_WDATA_o,
    output logic                                  s_WLAST_o,
    output logic                                  s_WVALID_o,
    input  logic                                  s_WREADY_i,
    output logic                                  outst_full_o
);

    localparam int PTR_W = (OUTSTANDING_AMT > 1) ? $clog2(OUTSTANDING_AMT) : 1;
    localparam int CNT_W = $clog2(OUTSTANDING_AMT + 1);

    // Handshakes: a transfer happens on a rising edge where VALID and READY are both 1;
    // VALID never depends on READY, and payload is held stable while VALID=1 and READY=0.

    logic                        r_aw_valid;
    logic [MST_ID_W-1:0]         r_aw_mst;
    logic [TRANS_MST_ID_W-1:0]   r_aw_id;
    logic [ADDR_WIDTH-1:0]       r_aw_addr;
    logic [TRANS_BURST_W-1:0]    r_aw_burst;
    logic [TRANS_DATA_LEN_W-1:0] r_aw_len;
    logic [TRANS_DATA_SIZE_W-1:0] r_aw_size;
    logic [MST_ID_W-1:0]         r_rr_ptr;

    logic [MST_ID_W-1:0]         r_order_q [OUTSTANDING_AMT];
    logic [PTR_W-1:0]            r_wr_ptr;
    logic [PTR_W-1:0]            r_rd_ptr;
    logic [CNT_W-1:0]            r_count;

    logic [2*MST_AMT-1:0]        w_dbl_valid;
    logic [MST_AMT-1:0]          w_rot_valid;
    logic                        w_grant_found;
    logic [MST_ID_W-1:0]         w_grant_idx;
    logic                        w_full;
    logic                        w_empty;
    logic                        w_can_grant;
    logic                        w_do_grant;
    logic                        w_pop;
    logic [MST_ID_W-1:0]         w_head;

    assign w_full  = (r_count == CNT_W'(OUTSTANDING_AMT));
    assign w_empty = (r_count == '0);
    assign w_head  = r_order_q[r_rd_ptr];
    assign outst_full_o = w_full;

    // Rotate requests so bit 0 is the master at the RR pointer; first set bit wins.
    assign w_dbl_valid = {dsp_AWVALID_i, dsp_AWVALID_i} >> r_rr_ptr;
    assign w_rot_valid = w_dbl_valid[MST_AMT-1:0];

    always_comb begin
        w_grant_found = 1'b0;
        w_grant_idx   = '0;
        for (int k = 0; k < MST_AMT; k++) begin
            if (!w_grant_found && w_rot_valid[k]) begin
                w_grant_found = 1'b1;
                if (int'(r_rr_ptr) + k >= MST_AMT)
                    w_grant_idx = MST_ID_W'(int'(r_rr_ptr) + k - MST_AMT);
                else
                    w_grant_idx = MST_ID_W'(int'(r_rr_ptr) + k);
            end
        end
    end

    assign w_can_grant   = (~r_aw_valid | s_AWREADY_i) & ~w_full & ARESETn_i;
    assign w_do_grant    = w_can_grant & w_grant_found;
    assign dsp_AWREADY_o = w_do_grant ? (MST_AMT'(1) << w_grant_idx) : '0;

    always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
        if (!ARESETn_i) begin
            r_aw_valid <= 1'b0;
            r_aw_mst   <= '0;
            r_aw_id    <= '0;
            r_aw_addr  <= '0;
            r_aw_burst <= '0;
            r_aw_len   <= '0;
            r_aw_size  <= '0;
            r_rr_ptr   <= '0;
        end else if (w_do_grant) begin
            r_aw_valid <= 1'b1;
            r_aw_mst   <= w_grant_idx;
            r_aw_id    <= dsp_AWID_i[w_grant_idx*TRANS_MST_ID_W +: TRANS_MST_ID_W];
            r_aw_addr  <= dsp_AWADDR_i[w_grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
            r_aw_burst <= dsp_AWBURST_i[w_grant_idx*TRANS_BURST_W +: TRANS_BURST_W];
            r_aw_len   <= dsp_AWLEN_i[w_grant_idx*TRANS_DATA_LEN_W +: TRANS_DATA_LEN_W];
            r_aw_size  <= dsp_AWSIZE_i[w_grant_idx*TRANS_DATA_SIZE_W +: TRANS_DATA_SIZE_W];
            r_rr_ptr   <= (w_grant_idx == MST_ID_W'(MST_AMT - 1)) ? '0 : w_grant_idx + 1'b1;
        end else if (r_aw_valid && s_AWREADY_i) begin
            r_aw_valid <= 1'b0;
        end
    end

    assign s_AWVALID_o = r_aw_valid;
    assign s_AWID_o    = {r_aw_mst, r_aw_id};
    assign s_AWADDR_o  = r_aw_addr;
    assign s_AWBURST_o = r_aw_burst;
    assign s_AWLEN_o   = r_aw_len;
    assign s_AWSIZE_o  = r_aw_size;

    // W path follows the FIFO head only; a master whose AW is not yet at the head waits.
    always_comb begin
        s_WDATA_o    = '0;
        s_WLAST_o    = 1'b0;
        s_WVALID_o   = 1'b0;
        dsp_WREADY_o = '0;
        if (!w_empty) begin
            s_WDATA_o            = dsp_WDATA_i[w_head*DATA_WIDTH +: DATA_WIDTH];
            s_WLAST_o            = dsp_WLAST_i[w_head];
            s_WVALID_o           = dsp_WVALID_i[w_head];
            dsp_WREADY_o[w_head] = s_WREADY_i;
        end
    end

    assign w_pop = s_WVALID_o & s_WREADY_i & s_WLAST_o;

    always_ff @(posedge ACLK_i) begin
        if (w_do_grant)
            r_order_q[r_wr_ptr] <= w_grant_idx;
    end

    always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
        if (!ARESETn_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_grant)
                r_wr_ptr <= (r_wr_ptr == PTR_W'(OUTSTANDING_AMT - 1)) ? '0 : r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= (r_rd_ptr == PTR_W'(OUTSTANDING_AMT - 1)) ? '0 : r_rd_ptr + 1'b1;
            case ({w_do_grant, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_sa_write_arbiter.sv
// Directed bench for sa_write_arbiter (2 masters, order FIFO depth 2).
module tb_sa_write_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  aw_valid, w_valid, w_last;
    logic        s_awready, s_wready;
    logic [2:0]  len0, len1;
    logic [31:0] addr0, addr1, wdata0, wdata1;

    logic [1:0]  dsp_AWREADY_o, dsp_WREADY_o;
    logic [5:0]  s_AWID_o;
    logic [31:0] s_AWADDR_o, s_WDATA_o;
    logic [1:0]  s_AWBURST_o;
    logic [2:0]  s_AWLEN_o, s_AWSIZE_o;
    logic        s_AWVALID_o, s_WLAST_o, s_WVALID_o, outst_full_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    sa_write_arbiter #(.MST_AMT(2), .OUTSTANDING_AMT(2)) dut (
        .ACLK_i        (clk),
        .ARESETn_i     (rst_n),
        .dsp_AWID_i    ({5'h11, 5'h0A}),
        .dsp_AWADDR_i  ({addr1, addr0}),
        .dsp_AWBURST_i ({2'b01, 2'b01}),
        .dsp_AWLEN_i   ({len1, len0}),
        .dsp_AWSIZE_i  ({3'b010, 3'b010}),
        .dsp_AWVALID_i (aw_valid),
        .dsp_AWREADY_o (dsp_AWREADY_o),
        .dsp_WDATA_i   ({wdata1, wdata0}),
        .dsp_WLAST_i   (w_last),
        .dsp_WVALID_i  (w_valid),
        .dsp_WREADY_o  (dsp_WREADY_o),
        .s_AWID_o      (s_AWID_o),
        .s_AWADDR_o    (s_AWADDR_o),
        .s_AWBURST_o   (s_AWBURST_o),
        .s_AWLEN_o     (s_AWLEN_o),
        .s_AWSIZE_o    (s_AWSIZE_o),
        .s_AWVALID_o   (s_AWVALID_o),
        .s_AWREADY_i   (s_awready),
        .s_WDATA_o     (s_WDATA_o),
        .s_WLAST_o     (s_WLAST_o),
        .s_WVALID_o    (s_WVALID_o),
        .s_WREADY_i    (s_wready),
        .outst_full_o  (outst_full_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; aw_valid = 2'b11; w_valid = 2'b11; w_last = 2'b11;
        s_awready = 1'b1; s_wready = 1'b1; len0 = 3'd0; len1 = 3'd0;
        addr0 = 32'h1000; addr1 = 32'h2000; wdata0 = 32'hA0; wdata1 = 32'hB0;

        // Reset with every VALID high
        repeat (2) @(negedge clk);
        #1;
        check("rst_awready", dsp_AWREADY_o, 2'b00);
        check("rst_wready",  dsp_WREADY_o,  2'b00);
        check("rst_awvalid", s_AWVALID_o,   1'b0);
        check("rst_wvalid",  s_WVALID_o,    1'b0);
        check("rst_full",    outst_full_o,  1'b0);
        check("rst_awaddr",  s_AWADDR_o,    32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_first_grant", dsp_AWREADY_o, 2'b01);

        // Round robin with both masters requesting; single-beat bursts drain immediately
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            #1;
            check("rr_grant", dsp_AWREADY_o, (k % 2 == 0) ? 2'b01 : 2'b10);
            check("rr_awid_msb", s_AWID_o[5], ((k - 1) % 2 == 0) ? 1'b0 : 1'b1);
            check("rr_wready", dsp_WREADY_o, ((k - 1) % 2 == 0) ? 2'b01 : 2'b10);
        end
        @(negedge clk);
        aw_valid = 2'b00;
        @(negedge clk);
        #1;
        check("rr_idle_awvalid", s_AWVALID_o, 1'b0);
        check("rr_idle_wvalid",  s_WVALID_o,  1'b0);

        // Order: m1 len=3 then m0 len=1
        @(negedge clk);
        aw_valid = 2'b10; len1 = 3'd3; len0 = 3'd1; w_last = 2'b00;
        #1;
        check("ord_grant_m1", dsp_AWREADY_o, 2'b10);
        check("ord_wvalid_pre", s_WVALID_o, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            aw_valid = (k == 1) ? 2'b01 : 2'b00;
            w_last = {(k == 4), (k == 6)};
            wdata1 = 32'hB000_0000 | k;
            wdata0 = 32'hA000_0000 | k;
            #1;
            if (k == 1) begin
                check("ord_grant_m0", dsp_AWREADY_o, 2'b01);
                check("ord_awid1", s_AWID_o, 6'h31);
                check("ord_awlen1", s_AWLEN_o, 3'd3);
            end
            if (k == 2) begin
                check("ord_awid0", s_AWID_o, 6'h0A);
                check("ord_awlen0", s_AWLEN_o, 3'd1);
            end
            check("ord_wready", dsp_WREADY_o, (k <= 4) ? 2'b10 : 2'b01);
            check("ord_wdata", s_WDATA_o, (k <= 4) ? (32'hB000_0000 | k) : (32'hA000_0000 | k));
            check("ord_wlast", s_WLAST_o, (k == 4 || k == 6) ? 1'b1 : 1'b0);
            check("ord_wvalid", s_WVALID_o, 1'b1);
        end
        @(negedge clk);
        w_last = 2'b00;
        #1;
        check("ord_empty", s_WVALID_o, 1'b0);

        // FIFO full: W stalled, three AWs offered
        @(negedge clk);
        s_wready = 1'b0; w_valid = 2'b00; aw_valid = 2'b11;
        #1;
        check("full_g1", dsp_AWREADY_o, 2'b10);
        @(negedge clk);
        #1;
        check("full_g2", dsp_AWREADY_o, 2'b01);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            #1;
            check("full_no_grant", dsp_AWREADY_o, 2'b00);
            check("full_flag", outst_full_o, 1'b1);
        end
        @(negedge clk);
        w_valid = 2'b10; w_last = 2'b10; s_wready = 1'b1;
        #1;
        check("full_pop_no_grant", dsp_AWREADY_o, 2'b00);
        check("full_pop_wready", dsp_WREADY_o, 2'b10);
        @(negedge clk);
        w_valid = 2'b00; s_wready = 1'b0;
        #1;
        check("full_g3", dsp_AWREADY_o, 2'b10);
        check("full_flag_clr", outst_full_o, 1'b0);
        @(negedge clk);
        aw_valid = 2'b00; w_valid = 2'b11; w_last = 2'b11; s_wready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("full_drained", s_WVALID_o, 1'b0);
        check("full_drained_flag", outst_full_o, 1'b0);

        // Slave AW backpressure
        @(negedge clk);
        w_valid = 2'b00; s_wready = 1'b0; s_awready = 1'b0; aw_valid = 2'b01;
        #1;
        check("bp_grant_m0", dsp_AWREADY_o, 2'b01);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            aw_valid = 2'b10; addr0 = 32'h1111_0000;
            #1;
            check("bp_no_grant", dsp_AWREADY_o, 2'b00);
            check("bp_awvalid", s_AWVALID_o, 1'b1);
            check("bp_awaddr", s_AWADDR_o, 32'h1000);
            check("bp_awid", s_AWID_o, 6'h0A);
        end
        @(negedge clk);
        s_awready = 1'b1;
        #1;
        check("bp_release_grant", dsp_AWREADY_o, 2'b10);
        @(negedge clk);
        aw_valid = 2'b00; addr0 = 32'h1000;
        #1;
        check("bp_next_addr", s_AWADDR_o, 32'h2000);
        check("bp_next_id", s_AWID_o, 6'h31);
        w_valid = 2'b11; w_last = 2'b11; s_wready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("bp_drained", s_WVALID_o, 1'b0);

        // Reset in the middle of a len=7 burst
        @(negedge clk);
        aw_valid = 2'b01; len0 = 3'd7; w_valid = 2'b01; w_last = 2'b00;
        #1;
        check("mid_grant", dsp_AWREADY_o, 2'b01);
        @(negedge clk);
        aw_valid = 2'b00;
        #1;
        check("mid_beat0", s_WVALID_o, 1'b1);
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_wvalid", s_WVALID_o, 1'b0);
        check("mid_rst_wready", dsp_WREADY_o, 2'b00);
        check("mid_rst_awvalid", s_AWVALID_o, 1'b0);
        check("mid_rst_full", outst_full_o, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("mid_post_wvalid", s_WVALID_o, 1'b0);
        check("mid_post_awready", dsp_AWREADY_o, 2'b00);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
